// File: rtl/mmx_scoreboard.sv
// ============================================================================
// mmx_scoreboard : MMX register RAW/WAW scoreboard with per-register counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module mmx_scoreboard #(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter int NUM_SRC  = 2,
   parameter int CNT_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      v_dec,
   input  logic [ADDR_W-1:0]         reg_op,
   input  logic [ADDR_W-1:0]         r_m,
   input  logic [1:0]                mod,
   input  logic [NUM_SRC-1:0]        src_rm,
   input  logic [NUM_SRC-1:0]        src_needed,
   input  logic                      ld_mm_in,
   input  logic                      dst_rm,
   input  logic                      dc_ready,
   input  logic                      flush,
   input  logic                      wb_valid,
   input  logic [ADDR_W-1:0]         wb_addr,
   output logic [NUM_SRC*ADDR_W-1:0] mm_src,
   output logic [ADDR_W-1:0]         dmm,
   output logic                      ld_mm,
   output logic                      stall,
   output logic                      issue,
   output logic [NUM_REGS-1:0]       busy_vec,
   output logic                      wb_err
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic [CNT_W-1:0]  cnt_q [NUM_REGS];
   logic [CNT_W-1:0]  cnt_d [NUM_REGS];
   logic              wb_err_q;
   logic              wb_err_d;

   logic [ADDR_W-1:0] w_src_addr [NUM_SRC];
   logic [NUM_SRC-1:0] w_src_chk;
   logic [NUM_REGS-1:0] w_busy;
   logic              w_dep;
   logic              w_dmm_full;
   logic              w_wb_ok;

   // A source that selects r/m is only a register operand when mod is 2'b11
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign w_src_addr[i]                = src_rm[i] ? r_m : reg_op;
      assign mm_src[i*ADDR_W +: ADDR_W]   = w_src_addr[i];
      assign w_src_chk[i]                 = src_needed[i] & (~src_rm[i] | (mod == 2'b11));
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
      assign w_busy[r] = |cnt_q[r];
   end

   assign dmm      = dst_rm ? r_m : reg_op;
   assign busy_vec = w_busy;
   assign wb_err   = wb_err_q;

   always_comb begin
      w_dep      = 1'b0;
      w_dmm_full = 1'b0;
      w_wb_ok    = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (w_src_chk[i] && (w_src_addr[i] == ADDR_W'(r)) && w_busy[r]) begin
               w_dep = 1'b1;
            end
         end
      end
      for (int r = 0; r < NUM_REGS; r++) begin
         if ((dmm == ADDR_W'(r)) && (cnt_q[r] == c_cnt_max)) begin
            w_dmm_full = 1'b1;
         end
         if ((wb_addr == ADDR_W'(r)) && w_busy[r]) begin
            w_wb_ok = 1'b1;
         end
      end
   end

   // Stall uses registered counts only; a writeback releases it one cycle later
   assign stall = v_dec & (w_dep | (ld_mm_in & w_dmm_full));
   assign issue = v_dec & dc_ready & ~stall & ~flush;
   assign ld_mm = ld_mm_in & issue;

   always_comb begin
      wb_err_d = wb_valid & ~flush & ~w_wb_ok;
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (flush) begin
            cnt_d[r] = '0;
         end else if (ld_mm && (dmm == ADDR_W'(r))) begin
            if (!(wb_valid && (wb_addr == ADDR_W'(r)) && w_busy[r]) && (cnt_q[r] != c_cnt_max)) begin
               cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end
         end else if (wb_valid && (wb_addr == ADDR_W'(r)) && w_busy[r]) begin
            cnt_d[r] = cnt_q[r] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_err_q <= 1'b0;
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         wb_err_q <= wb_err_d;
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mmx_scoreboard.sv
// ============================================================================
// tb_mmx_scoreboard : directed self-checking bench for mmx_scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mmx_scoreboard;

   logic       clk;
   logic       rst;
   logic       v_dec;
   logic [2:0] reg_op;
   logic [2:0] r_m;
   logic [1:0] mod;
   logic [1:0] src_rm;
   logic [1:0] src_needed;
   logic       ld_mm_in;
   logic       dst_rm;
   logic       dc_ready;
   logic       flush;
   logic       wb_valid;
   logic [2:0] wb_addr;
   logic [5:0] mm_src;
   logic [2:0] dmm;
   logic       ld_mm;
   logic       stall;
   logic       issue;
   logic [7:0] busy_vec;
   logic       wb_err;

   int n_checks = 0;
   int n_fail   = 0;

   mmx_scoreboard #(
      .NUM_REGS (8),
      .ADDR_W   (3),
      .NUM_SRC  (2),
      .CNT_W    (2)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .v_dec      (v_dec),
      .reg_op     (reg_op),
      .r_m        (r_m),
      .mod        (mod),
      .src_rm     (src_rm),
      .src_needed (src_needed),
      .ld_mm_in   (ld_mm_in),
      .dst_rm     (dst_rm),
      .dc_ready   (dc_ready),
      .flush      (flush),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .mm_src     (mm_src),
      .dmm        (dmm),
      .ld_mm      (ld_mm),
      .stall      (stall),
      .issue      (issue),
      .busy_vec   (busy_vec),
      .wb_err     (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      v_dec = 0; reg_op = 0; r_m = 0; mod = 2'b11; src_rm = 0; src_needed = 0;
      ld_mm_in = 0; dst_rm = 0; dc_ready = 1; flush = 0; wb_valid = 0; wb_addr = 0;
   endtask

   // Issue a pure write of MM<a> (no sources read)
   task automatic wr(input logic [2:0] a);
      idle();
      v_dec = 1; reg_op = a; ld_mm_in = 1;
   endtask

   task automatic wb(input logic [2:0] a);
      idle();
      wb_valid = 1; wb_addr = a;
   endtask

   initial begin
      idle();
      rst = 1;
      #2;
      check("rst_busy", 32'(busy_vec), 32'h00);
      check("rst_wb_err", 32'(wb_err), 32'h0);
      tick();
      rst = 0;
      tick();

      // Independent ops
      idle();
      v_dec = 1; reg_op = 1; r_m = 2; mod = 2'b11; src_rm = 2'b10; src_needed = 2'b11;
      ld_mm_in = 1; dst_rm = 0;
      #1;
      check("indep_issue", 32'(issue), 32'h1);
      check("indep_stall", 32'(stall), 32'h0);
      check("indep_mm_src", 32'(mm_src), 32'h11);
      check("indep_dmm", 32'(dmm), 32'h1);
      check("indep_ld_mm", 32'(ld_mm), 32'h1);
      tick();
      idle();
      #1;
      check("indep_busy", 32'(busy_vec), 32'h02);

      // RAW on MM1, writeback does not bypass
      v_dec = 1; reg_op = 1; src_rm = 2'b00; src_needed = 2'b01;
      #1;
      check("raw_stall", 32'(stall), 32'h1);
      check("raw_issue", 32'(issue), 32'h0);
      wb_valid = 1; wb_addr = 1;
      #1;
      check("raw_no_bypass", 32'(stall), 32'h1);
      tick();
      wb_valid = 0;
      #1;
      check("raw_wb_busy", 32'(busy_vec), 32'h00);
      check("raw_release_stall", 32'(stall), 32'h0);
      check("raw_release_issue", 32'(issue), 32'h1);
      dc_ready = 0;
      #1;
      check("no_ready_issue", 32'(issue), 32'h0);
      tick();

      // Simultaneous increment and decrement on MM3
      wr(3);
      tick();
      #1;
      check("sim_busy1", 32'(busy_vec), 32'h08);
      wr(3); wb_valid = 1; wb_addr = 3;
      #1;
      check("sim_issue", 32'(issue), 32'h1);
      tick();
      wb(3);
      #1;
      check("sim_busy2", 32'(busy_vec), 32'h08);
      check("sim_no_err", 32'(wb_err), 32'h0);
      tick();
      idle();
      #1;
      check("sim_one_wb_clears", 32'(busy_vec), 32'h00);

      // Saturation of MM4 at 3 outstanding writes
      wr(4);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("sat_issue", 32'(issue), 32'h1);
         tick();
      end
      #1;
      check("sat_stall", 32'(stall), 32'h1);
      check("sat_issue4", 32'(issue), 32'h0);
      check("sat_ld_mm4", 32'(ld_mm), 32'h0);
      tick();
      idle();
      #1;
      check("sat_busy", 32'(busy_vec), 32'h10);

      // Memory operand on r/m does not depend on busy MM5
      wr(5);
      tick();
      idle();
      #1;
      check("mem_busy", 32'(busy_vec), 32'h30);
      v_dec = 1; mod = 2'b00; r_m = 5; src_rm = 2'b01; src_needed = 2'b01;
      #1;
      check("mem_stall", 32'(stall), 32'h0);
      mod = 2'b11;
      #1;
      check("reg_rm_stall", 32'(stall), 32'h1);
      wb(5);
      tick();
      wr(1);
      tick();
      wr(3);
      tick();
      idle();
      #1;
      check("pre_flush_busy", 32'(busy_vec), 32'h1A);

      // Flush beats a concurrent issue and writeback
      wr(6); flush = 1; wb_valid = 1; wb_addr = 4;
      #1;
      check("flush_issue", 32'(issue), 32'h0);
      tick();
      wb(3);
      #1;
      check("flush_busy", 32'(busy_vec), 32'h00);
      check("flush_no_err", 32'(wb_err), 32'h0);
      tick();
      idle();
      #1;
      check("underflow_err", 32'(wb_err), 32'h1);
      check("underflow_busy", 32'(busy_vec), 32'h00);
      tick();
      check("underflow_pulse_end", 32'(wb_err), 32'h0);

      // Asynchronous reset between edges
      wr(2);
      tick();
      idle();
      #1;
      check("pre_rst_busy", 32'(busy_vec), 32'h04);
      #1;
      rst = 1;
      #1;
      check("async_rst_busy", 32'(busy_vec), 32'h00);
      #1;
      rst = 0;
      wr(6);
      tick();
      idle();
      #1;
      check("post_rst_busy", 32'(busy_vec), 32'h40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mmx_scoreboard.md
MMX_SCOREBOARD -- requirements
Module: mmx_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 8: number of MMX architectural registers tracked.
REQ-002 Parameter ADDR_W, default 3: register address width; NUM_REGS SHALL be at most 2**ADDR_W.
REQ-003 Parameter NUM_SRC, default 2: number of source operand ports, each 1 to 4.
REQ-004 Parameter CNT_W, default 2: width of each per-register outstanding-write counter.
REQ-005 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 v_dec  in  1  decode slot holds a valid instruction.
REQ-008 reg_op  in  ADDR_W  ModRM reg field.
REQ-009 r_m  in  ADDR_W  ModRM r/m field.
REQ-010 mod  in  2  ModRM mod field; 2'b11 means r/m names a register.
REQ-011 src_rm  in  NUM_SRC  per source: 1 selects r_m, 0 selects reg_op.
REQ-012 src_needed  in  NUM_SRC  per source: the operand is read.
REQ-013 ld_mm_in  in  1  instruction writes an MMX register.
REQ-014 dst_rm  in  1  destination select: 1 selects r_m, 0 selects reg_op.
REQ-015 dc_ready  in  1  downstream stage accepts an instruction this cycle.
REQ-016 flush  in  1  pipeline flush on a taken branch, return or EIP change.
REQ-017 wb_valid  in  1  an MMX register writeback completes this cycle.
REQ-018 wb_addr  in  ADDR_W  writeback register address.
REQ-019 mm_src  out  NUM_SRC*ADDR_W  selected source addresses; source i occupies bits [i*ADDR_W +: ADDR_W].
REQ-020 dmm  out  ADDR_W  selected destination address.
REQ-021 ld_mm  out  1  destination write enable passed down the pipe.
REQ-022 stall  out  1  decode SHALL hold.
REQ-023 issue  out  1  instruction leaves decode this cycle.
REQ-024 busy_vec  out  NUM_REGS  bit r SHALL be 1 when cnt[r] is nonzero.
REQ-025 wb_err  out  1  registered one-cycle pulse flagging an underflowed writeback.

Function
REQ-026 mm_src, dmm, stall, issue and ld_mm SHALL be combinational; counters and wb_err SHALL be registered.
REQ-027 Source i SHALL be dependency-checked only when src_needed[i] is 1, and when it selects r_m, only when mod is 2'b11.
REQ-028 stall SHALL be 1 when v_dec is 1 and either any checked source has a nonzero registered counter, or ld_mm_in is 1 and cnt[dmm] equals 2**CNT_W-1.
REQ-029 issue SHALL equal v_dec & dc_ready & ~stall & ~flush.
REQ-030 ld_mm SHALL equal ld_mm_in & issue.
REQ-031 On a cycle with issue and ld_mm_in, cnt[dmm] SHALL increment by 1.
REQ-032 On a cycle with wb_valid and cnt[wb_addr] nonzero, cnt[wb_addr] SHALL decrement by 1.
REQ-033 When an increment and a decrement target the same register in one cycle, that counter SHALL be unchanged.
REQ-034 A wb_valid to a zero counter, or with wb_addr of NUM_REGS or more, SHALL leave all counters unchanged and pulse wb_err the following cycle.
REQ-035 Stall release SHALL use registered counts only: a writeback clears a dependency-caused stall one cycle later, with no same-cycle bypass.
REQ-036 flush SHALL take precedence over issue and writeback and clear every counter at the next edge.
REQ-037 A writeback arriving after a flush SHALL be handled per REQ-034.
REQ-038 A counter SHALL never wrap in either direction.

Reset
REQ-039 While rst is high, all counters, busy_vec and wb_err SHALL be 0 immediately and independent of clk.
REQ-040 Reset asserted mid-operation SHALL discard all outstanding-write tracking.
REQ-041 The first edge after rst deasserts SHALL behave as normal operation.

Verification
REQ-042 Independent ops: v_dec=1, dc_ready=1, reg_op=1, r_m=2, mod=3, src_rm=2'b10, src_needed=2'b11, ld_mm_in=1, dst_rm=0 -> issue=1, mm_src={2,1}, dmm=1, and busy_vec becomes 8'h02 next cycle.
REQ-043 RAW dependency: after REQ-042, decode reads MM1 -> stall=1 and issue=0; wb_valid with wb_addr=1 -> busy_vec[1]=0 next cycle, then stall deasserts.
REQ-044 Simultaneous events and saturation: issue writing MM3 while wb_addr=3 with cnt[3]=1 -> cnt[3] stays 1; three issues writing MM4 with no writeback -> the fourth stalls with cnt[4]=3.
REQ-045 Memory operand: mod=0 with source selecting r_m=5 while MM5 is busy -> no stall.
REQ-046 Flush and underflow: flush with busy_vec=8'h1A -> busy_vec=0 next cycle; a following wb_valid with wb_addr=3 -> wb_err pulses high for exactly one cycle.
REQ-047 Async reset: rst asserted between edges with busy_vec nonzero -> busy_vec=0 immediately.
